exe_stage: RTL

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage_if.sv | 39 +++
 rtl/exe_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_if.sv
// exe_stage_if: handshake and data bundle for the execute stage.
//   slave  modport : execute stage view (consumes in_*, produces WB_* / out_valid)
//   master modport : driver view (upstream decode + downstream writeback)
// Signals:
//   in_valid/in_ready   : operation handshake from decode
//   Shift_Data, ALU_A   : shifter operand and ALU first operand
//   Shift_Num, Shift_op : shift amount and {type[1:0], by_reg}
//   ALU_op, W_Addr, Write_Reg, S : opcode, destination, write request, set flags
//   out_valid/out_ready : result handshake toward writeback
//   WB_Data, WB_Addr, WB_Write : registered writeback
interface exe_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Shift_Data;
    logic [31:0] ALU_A;
    logic [7:0]  Shift_Num;
    logic [2:0]  Shift_op;
    logic [3:0]  ALU_op;
    logic [3:0]  W_Addr;
    logic        Write_Reg;
    logic        S;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] WB_Data;
    logic [3:0]  WB_Addr;
    logic        WB_Write;

    modport slave (
        input  in_valid, Shift_Data, ALU_A, Shift_Num, Shift_op, ALU_op, W_Addr, Write_Reg, S,
        input  out_ready,
        output in_ready, out_valid, WB_Data, WB_Addr, WB_Write
    );

    modport master (
        output in_valid, Shift_Data, ALU_A, Shift_Num, Shift_op, ALU_op, W_Addr, Write_Reg, S,
        output out_ready,
        input  in_ready, out_valid, WB_Data, WB_Addr, WB_Write
    );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: ARM-style execute stage (barrel shifter + data-processing ALU) with a
// one-entry registered output and valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous kill of the output register and of this cycle's input
//   bus         : exe_stage_if.slave (operand/control inputs, writeback outputs)
//   NZCV        : architectural flags {N,Z,C,V}
//   retire_cnt  : count of accepted writing operations (only with EXE_PERF_CNT_EN)
// Optional feature macro: EXE_PERF_CNT_EN enables the retire_cnt port and counter.
module exe_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    exe_stage_if.slave  bus,
`ifdef EXE_PERF_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic [3:0]  NZCV
);

    logic [3:0]  nzcv_q;
    logic        out_valid_q;
    logic [31:0] wb_data_q;
    logic [3:0]  wb_addr_q;
    logic        wb_write_q;

    logic accept;
    logic c_flag;

    assign c_flag        = nzcv_q[1];
    assign bus.in_ready  = (!out_valid_q || bus.out_ready) && !flush;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.WB_Data   = wb_data_q;
    assign bus.WB_Addr   = wb_addr_q;
    assign bus.WB_Write  = wb_write_q;
    assign NZCV          = nzcv_q;

    // ---------------- barrel shifter ----------------
    logic [1:0]  sh_type;
    logic        by_reg;
    logic [31:0] op;
    logic [7:0]  amt8;
    logic [4:0]  amt5;
    logic [32:0] lsl_t;
    logic [32:0] lsr_t;
    logic [32:0] asr_t;
    logic [63:0] ror_t;
    logic [31:0] sh_res;
    logic        sh_c;

    assign sh_type = bus.Shift_op[2:1];
    assign by_reg  = bus.Shift_op[0];
    assign op      = bus.Shift_Data;

    always_comb begin
        sh_res = op;
        sh_c   = c_flag;
        amt8   = by_reg ? bus.Shift_Num : {3'b000, bus.Shift_Num[4:0]};
        amt5   = amt8[4:0];
        // Widened shifts expose the last bit shifted out next to the result.
        lsl_t  = {1'b0, op} << amt5;
        lsr_t  = {op, 1'b0} >> amt5;
        asr_t  = $signed({op, 1'b0}) >>> amt5;
        ror_t  = {op, op} >> amt5;

        if (!by_reg && (amt5 == 5'd0)) begin
            // Immediate #0 encodings: LSR/ASR mean #32, ROR means RRX.
            unique case (sh_type)
                2'b00: begin sh_res = op;                  sh_c = c_flag; end
                2'b01: begin sh_res = '0;                  sh_c = op[31]; end
                2'b10: begin sh_res = {32{op[31]}};        sh_c = op[31]; end
                2'b11: begin sh_res = {c_flag, op[31:1]};  sh_c = op[0];  end
            endcase
        end else if (amt8 == 8'd0) begin
            sh_res = op;
            sh_c   = c_flag;
        end else begin
            unique case (sh_type)
                2'b00: begin
                    if (amt8 < 8'd32) begin
                        sh_res = lsl_t[31:0];
                        sh_c   = lsl_t[32];
                    end else begin
                        sh_res = '0;
                        sh_c   = (amt8 == 8'd32) ? op[0] : 1'b0;
                    end
                end
                2'b01: begin
                    if (amt8 < 8'd32) begin
                        sh_res = lsr_t[32:1];
                        sh_c   = lsr_t[0];
                    end else begin
                        sh_res = '0;
                        sh_c   = (amt8 == 8'd32) ? op[31] : 1'b0;
                    end
                end
                2'b10: begin
                    if (amt8 < 8'd32) begin
                        sh_res = asr_t[32:1];
                        sh_c   = asr_t[0];
                    end else begin
                        sh_res = {32{op[31]}};
                        sh_c   = op[31];
                    end
                end
                2'b11: begin
                    // Rotation by a nonzero multiple of 32 leaves the operand intact.
                    if (amt5 == 5'd0) begin
                        sh_res = op;
                        sh_c   = op[31];
                    end else begin
                        sh_res = ror_t[31:0];
                        sh_c   = ror_t[31];
                    end
                end
            endcase
        end
    end

    // ---------------- ALU ----------------
    logic [31:0] alu_a;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic        alu_cin;
    logic        is_arith;
    logic [32:0] sum;
    logic        ovf;
    logic [31:0] res;
    logic        is_cmp;
    logic        upd_flags;
    logic        wb_write_d;
    logic [3:0]  nzcv_d;

    assign alu_a = bus.ALU_A;

    always_comb begin
        alu_x    = alu_a;
        alu_y    = sh_res;
        alu_cin  = 1'b0;
        is_arith = 1'b0;
        res      = '0;
        // Subtraction is x + ~y + cin so the carry-out is NOT borrow.
        unique case (bus.ALU_op)
            4'd2, 4'd10: begin alu_x = alu_a;  alu_y = ~sh_res; alu_cin = 1'b1;   is_arith = 1'b1; end
            4'd3:        begin alu_x = sh_res; alu_y = ~alu_a;  alu_cin = 1'b1;   is_arith = 1'b1; end
            4'd4, 4'd11: begin alu_x = alu_a;  alu_y = sh_res;  alu_cin = 1'b0;   is_arith = 1'b1; end
            4'd5:        begin alu_x = alu_a;  alu_y = sh_res;  alu_cin = c_flag; is_arith = 1'b1; end
            4'd6:        begin alu_x = alu_a;  alu_y = ~sh_res; alu_cin = c_flag; is_arith = 1'b1; end
            4'd7:        begin alu_x = sh_res; alu_y = ~alu_a;  alu_cin = c_flag; is_arith = 1'b1; end
            default:     ;
        endcase

        sum = {1'b0, alu_x} + {1'b0, alu_y} + {32'd0, alu_cin};
        ovf = (alu_x[31] == alu_y[31]) && (sum[31] != alu_x[31]);

        unique case (bus.ALU_op)
            4'd0, 4'd8:  res = alu_a & sh_res;
            4'd1, 4'd9:  res = alu_a ^ sh_res;
            4'd12:       res = alu_a | sh_res;
            4'd13:       res = sh_res;
            4'd14:       res = alu_a & ~sh_res;
            4'd15:       res = ~sh_res;
            default:     res = sum[31:0];
        endcase
    end

    assign is_cmp     = (bus.ALU_op[3:2] == 2'b10);
    assign upd_flags  = bus.S || is_cmp;
    assign wb_write_d = bus.Write_Reg && !is_cmp;
    assign nzcv_d     = {res[31], (res == 32'd0),
                         is_arith ? sum[32] : sh_c,
                         is_arith ? ovf : nzcv_q[0]};

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            wb_data_q   <= '0;
            wb_addr_q   <= '0;
            wb_write_q  <= 1'b0;
            nzcv_q      <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            wb_data_q   <= res;
            wb_addr_q   <= bus.W_Addr;
            wb_write_q  <= wb_write_d;
            if (upd_flags) begin
                nzcv_q <= nzcv_d;
            end
        end else if (bus.out_ready || flush) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef EXE_PERF_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (accept && wb_write_d) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule
